// File: rtl/mul_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mul_seq
// Brief    : Iterative shift-add multiplier for the MUL instruction. Stalls the
//            core while running and issues one write-back strobe with the low
//            WIDTH bits of the product. Optional macro: MUL_SEQ_EARLY_EXIT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module mul_seq #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [4:0]       rd_in,
   output logic             stall,
   output logic             done,
   output logic             wr_en,
   output logic [4:0]       rd_out,
   output logic [WIDTH-1:0] result
);

   localparam int                 c_cnt_w = $clog2(WIDTH) + 1;
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
   localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

   typedef enum logic [1:0] {
      st_idle = 2'd0,
      st_run  = 2'd1,
      st_done = 2'd2
   } state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [c_cnt_w-1:0] r_cnt;
   logic [WIDTH-1:0]   r_result;
   logic [4:0]         r_rd;
   logic               r_done;

   logic [WIDTH-1:0]   w_acc_next;
   logic [WIDTH-1:0]   w_mplier_next;
   logic               w_last;

   assign w_acc_next    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
   assign w_mplier_next = r_mplier >> 1;

`ifdef MUL_SEQ_EARLY_EXIT_EN
   // No set bits left in the multiplier means no further adds can change acc.
   assign w_last = (r_cnt == c_last) || (w_mplier_next == '0);
`else
   assign w_last = (r_cnt == c_last);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= st_idle;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_rd     <= '0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            st_idle: begin
               r_done <= 1'b0;
               if (start) begin
                  r_mcand  <= a;
                  r_mplier <= b;
                  r_rd     <= rd_in;
                  r_acc    <= '0;
                  r_cnt    <= '0;
                  r_state  <= st_run;
               end
            end
            st_run: begin
               r_acc    <= w_acc_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= w_mplier_next;
               r_cnt    <= r_cnt + c_one;
               if (w_last) begin
                  r_result <= w_acc_next;
                  r_done   <= 1'b1;
                  r_state  <= st_done;
               end
            end
            st_done: begin
               // The same MUL is still presented here, so start is ignored.
               r_done  <= 1'b0;
               r_state <= st_idle;
            end
            default: begin
               r_done  <= 1'b0;
               r_state <= st_idle;
            end
         endcase
      end
   end

   // Combinational so the PC is released in the DONE cycle itself.
   assign stall  = !reset && (((r_state == st_idle) && start) || (r_state == st_run));
   assign done   = r_done;
   assign wr_en  = r_done;
   assign rd_out = r_rd;
   assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_mul_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_mul_seq
// Brief    : Self-checking bench for mul_seq (WIDTH=64); table of directed
//            multiplies plus reset and hold-through-DONE sequences.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_mul_seq;

   localparam int c_width = 64;

   logic               clk;
   logic               reset;
   logic               start;
   logic [c_width-1:0] a;
   logic [c_width-1:0] b;
   logic [4:0]         rd_in;
   logic               stall;
   logic               done;
   logic               wr_en;
   logic [4:0]         rd_out;
   logic [c_width-1:0] result;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic [4:0]  rd;
      logic [63:0] res;
      bit          scr;
   } vec_t;

   vec_t vecs[9];

   mul_seq #(.WIDTH(c_width)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .a      (a),
      .b      (b),
      .rd_in  (rd_in),
      .stall  (stall),
      .done   (done),
      .wr_en  (wr_en),
      .rd_out (rd_out),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Number of RUN cycles the multiplier should spend for operand b.
   function automatic int exp_run(input logic [63:0] bv);
      int n;
`ifdef MUL_SEQ_EARLY_EXIT_EN
      n = 1;
      for (int i = 0; i < 64; i++)
         if (bv[i]) n = i + 1;
`else
      n = c_width;
`endif
      return n;
   endfunction

   // Called just after a falling edge; start is held until DONE is seen.
   task automatic run_mul(input logic [63:0] av, input logic [63:0] bv, input logic [4:0] rdv,
                          input logic [63:0] exp, input bit scr, input string nm);
      int k;
      int st_cnt;
      int er;
      bit seen;
      a = av; b = bv; rd_in = rdv; start = 1'b1;
      #1;
      er = exp_run(bv);
      st_cnt = 0;
      seen = 1'b0;
      for (k = 0; k < 200; k++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (stall) st_cnt++;
         @(negedge clk);
         if (scr && k == 0) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            rd_in = 5'($urandom);
         end
         #1;
      end
      check({nm, " done_seen"}, 64'(seen), 64'd1);
      check({nm, " done_cycle"}, 64'(k), 64'(er + 1));
      check({nm, " stall_cycles"}, 64'(st_cnt), 64'(er + 1));
      check({nm, " stall_in_done"}, 64'(stall), 64'd0);
      check({nm, " wr_en"}, 64'(wr_en), 64'd1);
      check({nm, " result"}, result, exp);
      check({nm, " rd_out"}, 64'(rd_out), 64'(rdv));
      // start still high across the DONE edge; dropped in the following IDLE.
      @(negedge clk);
      start = 1'b0;
      #1;
      check({nm, " one_pulse"}, 64'(wr_en), 64'd0);
      check({nm, " no_restart"}, 64'(stall), 64'd0);
      check({nm, " result_hold"}, result, exp);
      @(negedge clk);
   endtask

   initial begin
      vecs[0] = '{64'd3, 64'd5, 5'd9, 64'd15, 1'b0};
      vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
      vecs[2] = '{64'h8000_0000_0000_0000, 64'd2, 5'd31, 64'd0, 1'b0};
      vecs[3] = '{64'd6, 64'd7, 5'd4, 64'd42, 1'b0};
      vecs[4] = '{64'd7, 64'd0, 5'd3, 64'd0, 1'b0};
      vecs[5] = '{64'h1234_5678, 64'h1000, 5'd7, 64'h0000_0123_4567_8000, 1'b1};
      vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd17, 64'd1, 1'b0};
      vecs[7] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd22, 64'hFFFF_FFFE_0000_0001, 1'b1};
      vecs[8] = '{64'd1, 64'h8000_0000_0000_0000, 5'd0, 64'h8000_0000_0000_0000, 1'b0};

      reset = 1'b1; start = 1'b1; a = 64'd3; b = 64'd5; rd_in = 5'd9;
      repeat (2) @(negedge clk);
      #1;
      check("reset stall", 64'(stall), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset wr_en", 64'(wr_en), 64'd0);
      check("reset result", result, 64'd0);
      check("reset rd_out", 64'(rd_out), 64'd0);
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 9; i++)
         run_mul(vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].res, vecs[i].scr, $sformatf("vec%0d", i));

      // Reset in the middle of RUN drops the pending write-back.
      a = 64'd3; b = 64'd5; rd_in = 5'd9; start = 1'b1;
      repeat (11) @(negedge clk);
      reset = 1'b1;
      #1;
      check("midrun stall", 64'(stall), 64'd0);
      check("midrun done", 64'(done), 64'd0);
      check("midrun result", result, 64'd0);
      check("midrun rd_out", 64'(rd_out), 64'd0);
      @(negedge clk);
      #1;
      check("midrun wr_en", 64'(wr_en), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      run_mul(64'd6, 64'd7, 5'd12, 64'd42, 1'b0, "rst_restart");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mul_seq.md
# mul_seq

Iterative shift-add multiply sequencer for the single-cycle datapath's MUL instruction (mush = 2'b10 path). The main controller raises `start` when it decodes MUL. This block then stalls PC advance and register-file writes for the duration of the multiply, and issues a single write-back strobe with the low WIDTH bits of the product. It replaces the combinational multiplier in the writeback mux, trading latency for area.

## Interface
- WIDTH, 64, operand and result width; must be a power of two ≥ 4
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  MUL decoded this cycle; level, held by the controller while the instruction is present
- a  in  WIDTH  multiplicand (Rn read data)
- b  in  WIDTH  multiplier (Rm read data)
- rd_in  in  5  destination register index (instruction[4:0])
- stall  out  1  hold PC and suppress main-controller RegWrite
- done  out  1  one-cycle pulse; product valid
- wr_en  out  1  register-file write strobe for the product; equals done
- rd_out  out  5  destination index latched at start
- result  out  WIDTH  product, low WIDTH bits

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- Reset values: acc, mcand, mplier, cnt, result = 0; rd_out = 0; done = wr_en = 0. stall = 0 while reset is high.
- IDLE:
  - On `start`, latch mcand = a, mplier = b, rd_out = rd_in; clear acc = 0 and cnt = 0; go to RUN.
  - `a`, `b` and `rd_in` are sampled only at this edge.
- RUN, each edge:
  - If mplier[0], acc = acc + mcand (mod 2^WIDTH).
  - Then mcand <<= 1, mplier >>= 1, cnt += 1.
  - cnt is $clog2(WIDTH)+1 bits.
  - Exit to DONE on the edge where cnt reaches WIDTH-1 before increment, i.e. after exactly WIDTH RUN cycles.
  - On that exit edge, result is loaded with the final acc, including that edge's add.
- DONE (one cycle): done = wr_en = 1 and rd_out is valid. `start` is ignored here because the same MUL is still presented. Next state is IDLE unconditionally.
- stall = (state==IDLE && start) || state==RUN. It is combinational and low in DONE, so the PC advances at the DONE edge.
- result holds its value until the next exit to DONE. acc is internal only.
- Arithmetic is unsigned. The low WIDTH bits are identical for signed operands, so no sign handling is needed. Overflow is discarded and no flags are produced.
- Reset asserted mid-RUN or in DONE: return to IDLE immediately, clear all registers, and suppress the pending write-back.

## Timing
- Edge E0 samples `start` in IDLE. RUN is active for cycles E0..E(WIDTH). DONE occupies the cycle after E(WIDTH). The return to IDLE happens at E(WIDTH+1).
- Full latency (macro off) is WIDTH+2 cycles from `start` high to the next instruction fetch. stall is high for WIDTH+1 cycles.
- `start` deasserted during RUN has no effect; the operation completes.
- Back-to-back MULs: the second `start` is accepted in the IDLE cycle after DONE. There is no bubble beyond that one cycle.

## Configuration
- MUL_SEQ_EARLY_EXIT_EN
  - Defined: RUN also exits to DONE on the edge where the shifted mplier becomes 0. RUN lasts max(1, index of b's highest set bit + 1) cycles, capped at WIDTH. The result is unchanged.
  - Undefined: RUN is always exactly WIDTH cycles, giving deterministic latency.

## Test plan
- WIDTH=64, macro off, a=3, b=5, rd_in=9, `start` held high:
  - stall high for 65 cycles.
  - DONE in cycle 66 with result=15, rd_out=9, wr_en=1 for exactly one cycle.
  - stall low in DONE.
- Macro on, same stimulus: 3 RUN cycles; done in cycle 5 after `start` with result=15. Then a=7, b=0: 1 RUN cycle, result=0.
- Wrap: a=0xFFFF_FFFF_FFFF_FFFF, b=2 → result=0xFFFF_FFFF_FFFF_FFFE. Then a=2^63, b=2 → result=0.
- `start` held through DONE → exactly one wr_en pulse, no restart. Re-asserting `start` in the next IDLE launches a second multiply, e.g. 6×7 → 42.
- Reset pulsed at RUN cycle 10 → state IDLE, stall=0, result=0, no wr_en pulse. Releasing reset with `start` high begins a fresh operation.
- Change `a`/`b`/`rd_in` during RUN → result and rd_out reflect only the values sampled at E0.
